// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, MSB first, feeding a downstream SIPO shift chain.
// Valid/ready input handshake, optional idle gap after each word, one-cycle frame strobe.
module serial_word_tx #(
    parameter int WIDTH = 6,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [7:0]       gcnt;
    logic             accept;

    // A new word may follow the last bit directly only when no gap is configured.
    assign din_ready = (state == S_IDLE) ||
                       ((state == S_SHIFT) && (cnt == CNT_LAST) && (GAP == 0));
    assign accept    = din_valid && din_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sreg        <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            sout        <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sreg  <= din;
                        sout  <= din[WIDTH-1];
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt != CNT_LAST) begin
                        // Rotate so the next lower bit of the word is always at WIDTH-2.
                        sreg <= {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                        sout <= sreg[WIDTH-2];
                        cnt  <= cnt + 1'b1;
                    end else begin
                        frame_valid <= 1'b1;
                        if (accept) begin
                            sreg  <= din;
                            sout  <= din[WIDTH-1];
                            cnt   <= '0;
                            state <= S_SHIFT;
                        end else if (GAP > 0) begin
                            state <= S_GAP;
                            gcnt  <= '0;
                            sout  <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            sout  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    sout  <= 1'b0;
                end
            endcase
        end
    end

endmodule
